register_file_param: RTL and testbench

//  Parametrised general-purpose register file for the pipelined datapath.

---
 rtl/register_file_param_if.sv | 46 ++++
 rtl/register_file_param.sv | 102 ++++++++++
 tb/tb_register_file_param.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_param_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// register_file_param_if
// Bus between the pipeline (decode/writeback) and the parametrised register
// file.
//   master : pipeline side, drives write/issue/read indices, receives read
//            data and scoreboard status
//   slave  : register file side
// Signals
//   regWrite       writeback strobe
//   writeRegister  writeback destination index          [ADDR_W]
//   writeData      writeback data                       [DATA_W]
//   issueValid     decode issued a producer of issueRegister
//   issueRegister  destination index to mark pending    [ADDR_W]
//   readRegister   packed read indices, port k at [k*ADDR_W +: ADDR_W]
//   readData       packed read data,    port k at [k*DATA_W +: DATA_W]
//   readPending    per-port pending flag                [NUM_RD]
//   anyPending     OR of all registered pending bits
// -----------------------------------------------------------------------------
interface register_file_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
);
    logic                     regWrite;
    logic [ADDR_W-1:0]        writeRegister;
    logic [DATA_W-1:0]        writeData;
    logic                     issueValid;
    logic [ADDR_W-1:0]        issueRegister;
    logic [NUM_RD*ADDR_W-1:0] readRegister;
    logic [NUM_RD*DATA_W-1:0] readData;
    logic [NUM_RD-1:0]        readPending;
    logic                     anyPending;

    modport master (
        output regWrite, writeRegister, writeData,
        output issueValid, issueRegister, readRegister,
        input  readData, readPending, anyPending
    );

    modport slave (
        input  regWrite, writeRegister, writeData,
        input  issueValid, issueRegister, readRegister,
        output readData, readPending, anyPending
    );
endinterface

// File: rtl/register_file_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// register_file_param
// Parametrised general-purpose register file with a per-register pending-write
// scoreboard for hazard detection. Reads are combinational on every port;
// writes and scoreboard updates happen on the rising clock edge.
// Ports
//   clock  in  rising-edge clock
//   reset  in  asynchronous active-low reset, clears registers and pending bits
//   bus    slave modport of register_file_param_if (write, issue, read ports)
// Parameters
//   DATA_W    data width
//   ADDR_W    index width, depth = 2**ADDR_W
//   NUM_RD    number of read ports
//   ZERO_REG  1: register 0 is hard-wired to zero and never pending
//   BYPASS    1: same-cycle write data forwarded to matching reads, pending masked
// The interface instance must be built with the same DATA_W/ADDR_W/NUM_RD.
// -----------------------------------------------------------------------------
module register_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clock,
    input  logic                reset,
    register_file_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] w_regs [DEPTH];
    logic [DEPTH-1:0]  w_pending;

    genvar gi;

    // Storage: one slice per register. Register state is cleared by the
    // asynchronous reset, so it is built from flops rather than a RAM.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (ZERO_REG != 0 && gi == 0) begin : g_zero
                assign w_regs[gi]    = '0;
                assign w_pending[gi] = 1'b0;
            end else begin : g_live
                logic              w_wr_hit;
                logic              w_iss_hit;
                logic [DATA_W-1:0] r_data;
                logic              r_pend;

                assign w_wr_hit  = bus.regWrite   && (bus.writeRegister == ADDR_W'(gi));
                assign w_iss_hit = bus.issueValid && (bus.issueRegister == ADDR_W'(gi));

                always_ff @(posedge clock or negedge reset) begin
                    if (!reset) begin
                        r_data <= '0;
                        r_pend <= 1'b0;
                    end else begin
                        if (w_wr_hit) begin
                            r_data <= bus.writeData;
                        end
                        // A new producer issued in the same cycle as the old
                        // one retires keeps the register pending.
                        if (w_iss_hit) begin
                            r_pend <= 1'b1;
                        end else if (w_wr_hit) begin
                            r_pend <= 1'b0;
                        end
                    end
                end

                assign w_regs[gi]    = r_data;
                assign w_pending[gi] = r_pend;
            end
        end
    endgenerate

    // Read ports, each fully independent.
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_idx;
            logic              w_fwd;

            assign w_idx = bus.readRegister[gi*ADDR_W +: ADDR_W];

            if (BYPASS != 0) begin : g_byp
                // Forwarding is suppressed while reset is held so that reads
                // return zero immediately, even with a write still on the bus.
                assign w_fwd = reset && bus.regWrite && (bus.writeRegister == w_idx)
                               && !(ZERO_REG != 0 && w_idx == '0);
            end else begin : g_nobyp
                assign w_fwd = 1'b0;
            end

            assign bus.readData[gi*DATA_W +: DATA_W] = w_fwd ? bus.writeData : w_regs[w_idx];
            assign bus.readPending[gi]               = w_pending[w_idx] & ~w_fwd;
        end
    endgenerate

    // Registered pending bits only; same-cycle bypass masking is per port.
    assign bus.anyPending = |w_pending;

endmodule

// File: tb/tb_register_file_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_register_file_param
// Three instances: A (32b, 16 regs, 2 ports, zero reg, bypass),
// B (same geometry, no zero reg, no bypass) sharing A's stimulus, and
// C (8b, 8 regs, 3 ports) for the small-geometry sweep.
// A and B are checked every cycle against array models of the register
// contents and pending sets.
// -----------------------------------------------------------------------------
module tb_register_file_param;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    register_file_param_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2)) bus_a ();
    register_file_param_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2)) bus_b ();
    register_file_param_if #(.DATA_W(8),  .ADDR_W(3), .NUM_RD(3)) bus_c ();

    register_file_param #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1))
        u_a (.clock(clock), .reset(reset), .bus(bus_a));
    register_file_param #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0))
        u_b (.clock(clock), .reset(reset), .bus(bus_b));
    register_file_param #(.DATA_W(8),  .ADDR_W(3), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1))
        u_c (.clock(clock), .reset(reset), .bus(bus_c));

    int n_vec = 0;
    int n_err = 0;
    int n_cyc = 0;

    // Reference state
    logic [31:0] ma_reg [16];
    logic [31:0] mb_reg [16];
    logic [15:0] ma_pend;
    logic [15:0] mb_pend;

    // Current stimulus
    logic        s_we;
    logic [3:0]  s_wa;
    logic [31:0] s_wd;
    logic        s_iv;
    logic [3:0]  s_ia;
    logic [3:0]  s_rr [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            ma_reg[i] = '0;
            mb_reg[i] = '0;
        end
        ma_pend = '0;
        mb_pend = '0;
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic iv, input logic [3:0] ia,
                         input logic [3:0] r0, input logic [3:0] r1);
        s_we = we; s_wa = wa; s_wd = wd; s_iv = iv; s_ia = ia;
        s_rr[0] = r0; s_rr[1] = r1;
        bus_a.regWrite = we; bus_a.writeRegister = wa; bus_a.writeData = wd;
        bus_a.issueValid = iv; bus_a.issueRegister = ia; bus_a.readRegister = {r1, r0};
        bus_b.regWrite = we; bus_b.writeRegister = wa; bus_b.writeData = wd;
        bus_b.issueValid = iv; bus_b.issueRegister = ia; bus_b.readRegister = {r1, r0};
    endtask

    // Expected outputs from the model state plus the current bus inputs.
    task automatic compare();
        logic [3:0]  idx;
        logic [31:0] ea;
        logic        pa;
        for (int k = 0; k < 2; k++) begin
            idx = s_rr[k];
            if (idx == 4'd0) begin
                ea = '0; pa = 1'b0;
            end else if (reset && s_we && s_wa == idx) begin
                ea = s_wd; pa = 1'b0;
            end else begin
                ea = ma_reg[idx]; pa = ma_pend[idx];
            end
            check($sformatf("A_rd%0d", k), bus_a.readData[k*32 +: 32], ea);
            check($sformatf("A_pend%0d", k), 32'(bus_a.readPending[k]), 32'(pa));
            check($sformatf("B_rd%0d", k), bus_b.readData[k*32 +: 32], mb_reg[idx]);
            check($sformatf("B_pend%0d", k), 32'(bus_b.readPending[k]), 32'(mb_pend[idx]));
        end
        check("A_any", 32'(bus_a.anyPending), 32'(|ma_pend));
        check("B_any", 32'(bus_b.anyPending), 32'(|mb_pend));
    endtask

    task automatic set_and_check(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                 input logic iv, input logic [3:0] ia,
                                 input logic [3:0] r0, input logic [3:0] r1);
        drive(we, wa, wd, iv, ia, r0, r1);
        #2;
        compare();
        n_cyc++;
        $display("cyc %0d rst_n=%b we=%b wa=%0d wd=%h iv=%b ia=%0d rr=%0d,%0d -> A=%h,%h B=%h,%h",
                 n_cyc, reset, we, wa, wd, iv, ia, r0, r1,
                 bus_a.readData[31:0], bus_a.readData[63:32],
                 bus_b.readData[31:0], bus_b.readData[63:32]);
    endtask

    // Clock edge: apply the architectural rules to the model.
    task automatic step();
        @(posedge clock);
        if (reset) begin
            if (s_we && s_wa != 4'd0) ma_reg[s_wa] = s_wd;
            if (s_we) ma_pend[s_wa] = 1'b0;
            if (s_iv) ma_pend[s_ia] = 1'b1;
            ma_pend[0] = 1'b0;
            if (s_we) mb_reg[s_wa] = s_wd;
            if (s_we) mb_pend[s_wa] = 1'b0;
            if (s_iv) mb_pend[s_ia] = 1'b1;
        end
        #1;
    endtask

    task automatic random_cycles(input int n);
        logic [3:0] wa;
        logic [3:0] r0;
        for (int i = 0; i < n; i++) begin
            wa = 4'($urandom_range(0, 15));
            r0 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            set_and_check(1'($urandom_range(0, 1)), wa, $urandom,
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          r0, 4'($urandom_range(0, 15)));
            step();
        end
    endtask

    initial begin
        logic [2:0] cidx [3];

        reset = 1'b0;
        model_clear();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        bus_c.regWrite = 1'b0; bus_c.writeRegister = '0; bus_c.writeData = '0;
        bus_c.issueValid = 1'b0; bus_c.issueRegister = '0; bus_c.readRegister = '0;

        // Reset state
        #12;
        set_and_check(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd5, 4'd9);
        #9 reset = 1'b1;
        @(posedge clock);
        #1;

        // Write then read back on both ports
        set_and_check(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 4'd6, 4'd5);
        step();
        set_and_check(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd5, 4'd5);
        check("t2_A_p0", bus_a.readData[31:0],  32'hDEADBEEF);
        check("t2_A_p1", bus_a.readData[63:32], 32'hDEADBEEF);
        check("t2_B_p0", bus_b.readData[31:0],  32'hDEADBEEF);
        step();
        set_and_check(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd6, 4'd5);
        check("t2_A_r6", bus_a.readData[31:0], 32'h0);
        step();

        // Zero register: write and issue r0
        set_and_check(1'b1, 4'd0, 32'h1234, 1'b1, 4'd0, 4'd0, 4'd0);
        check("t3_A_byp0", bus_a.readData[31:0], 32'h0);
        step();
        set_and_check(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        check("t3_A_r0",   bus_a.readData[31:0], 32'h0);
        check("t3_A_pend", 32'(bus_a.readPending[0]), 32'h0);
        check("t3_A_any",  32'(bus_a.anyPending), 32'h0);
        check("t3_B_r0",   bus_b.readData[31:0], 32'h1234);
        step();

        // Bypass with r3 pending
        set_and_check(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 4'd0, 4'd0);
        step();
        set_and_check(1'b1, 4'd3, 32'hA5A5A5A5, 1'b0, 4'd0, 4'd3, 4'd3);
        check("t4_A_byp",  bus_a.readData[31:0], 32'hA5A5A5A5);
        check("t4_A_mask", 32'(bus_a.readPending[0]), 32'h0);
        check("t4_B_old",  bus_b.readData[31:0], 32'h0);
        check("t4_B_pend", 32'(bus_b.readPending[0]), 32'h1);
        step();

        // Scoreboard collision on r7
        set_and_check(1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 4'd7, 4'd0);
        step();
        set_and_check(1'b1, 4'd7, 32'h11111111, 1'b1, 4'd7, 4'd0, 4'd0);
        step();
        set_and_check(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd7, 4'd0);
        check("t5_A_set",  32'(bus_a.readPending[0]), 32'h1);
        check("t5_A_any1", 32'(bus_a.anyPending), 32'h1);
        step();
        set_and_check(1'b1, 4'd7, 32'h22222222, 1'b0, 4'd0, 4'd0, 4'd0);
        step();
        set_and_check(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd7, 4'd7);
        check("t5_A_clr",  32'(bus_a.readPending[0]), 32'h0);
        check("t5_A_any0", 32'(bus_a.anyPending), 32'h0);
        check("t5_A_data", bus_a.readData[31:0], 32'h22222222);
        step();

        // Randomised traffic
        random_cycles(300);

        // Reset mid-cycle with a write and an issue on the bus
        set_and_check(1'b1, 4'd5, $urandom, 1'b1, 4'd9, 4'd5, 4'd9);
        reset = 1'b0;
        #1;
        model_clear();
        compare();
        check("t1_A_any", 32'(bus_a.anyPending), 32'h0);
        check("t1_A_rd0", bus_a.readData[31:0], 32'h0);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd5, 4'd9);
        #3 reset = 1'b1;
        @(posedge clock);
        #1;
        set_and_check(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd5, 4'd9);
        step();
        random_cycles(20);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 4'd0);

        // Small geometry: fill with index*17, read three ports in parallel
        for (int i = 0; i < 8; i++) begin
            bus_c.regWrite      = 1'b1;
            bus_c.writeRegister = 3'(i);
            bus_c.writeData     = 8'(i * 17);
            @(posedge clock);
            #1;
        end
        bus_c.regWrite = 1'b0;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 3; k++) cidx[k] = 3'($urandom_range(0, 7));
            if (c == 0) begin
                cidx[0] = 3'd7; cidx[1] = 3'd2; cidx[2] = 3'd5;
            end
            bus_c.readRegister = {cidx[2], cidx[1], cidx[0]};
            #2;
            for (int k = 0; k < 3; k++) begin
                check($sformatf("C_rd%0d", k), 32'(bus_c.readData[k*8 +: 8]), 32'(cidx[k]) * 32'd17);
            end
            $display("C read idx=%0d,%0d,%0d -> %0d,%0d,%0d", cidx[0], cidx[1], cidx[2],
                     bus_c.readData[7:0], bus_c.readData[15:8], bus_c.readData[23:16]);
            @(posedge clock);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
